game_stats_ctrl: RTL and testbench
==================================

# game_stats_ctrl

Synchronous score/lives keeper between the game's event logic (collision, scoring triggers) and the scoreboard digit renderer. It accepts point-add requests over a valid/ready handshake and hit pulses, and maintains a 3-digit BCD score and a lives count. It also tracks a frame-based invulnerability window and a game-over state. Its digit outputs drive the scoreboard generator's score and lives inputs directly.

## Interface
- START_LIVES, 3: lives loaded at reset and on start (1..9)
- MAX_LIVES, 9: saturation ceiling for lives (START_LIVES..15)
- INVULN_FRAMES, 60: frames of hit immunity after a life is lost (0..255; 0 disables)

- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high
- vsync  in  1  frame sync from video sync generator; rising edge = frame tick
- start  in  1  one-cycle pulse; restart game
- add_valid  in  1  point-add request
- add_points  in  4  points to add, BCD 0..9; values 10..15 clamp to 9
- add_ready  out  1  request accepted when valid&&ready at rising clk
- hit  in  1  one-cycle pulse; player hit
- score0  out  4  BCD ones
- score1  out  4  BCD tens
- score2  out  4  BCD hundreds
- lives  out  4  remaining lives, binary
- invuln  out  1  invulnerability window active
- game_over  out  1  high in OVER state

## Operation
- FSM states: PLAY, ADD0, ADD1, ADD2, OVER.
- add_ready = (state==PLAY).
- PLAY:
  - Handshake latches the clamped points and goes to ADD0.
  - Else if lives==0, go to OVER.
- ADD0: s = score0 + pts.
  - s≥10: score0 = s−10, go to ADD1.
  - Else: score0 = s, go to PLAY.
- ADD1: score1 = 9 ? score1 = 0 and go to ADD2 : score1+1 and go to PLAY.
- ADD2: score2 = 9 ? 0 (999→000 wrap) : score2+1; raise the hundreds-carry event; go to PLAY.
- Hit handling (any state except OVER):
  - Accepted if hit && invuln counter==0 && lives>0.
  - Effect: lives decrement; counter loads INVULN_FRAMES.
- Invuln counter, 8 bits:
  - Decrements by 1 per vsync rising-edge tick while nonzero.
  - Edge detect uses a registered vsync_d; tick = vsync & ~vsync_d.
- invuln = (counter != 0).
- Simultaneous hit and extra life in the same cycle: lives_next = lives + inc − dec, saturated to 0..MAX_LIVES.
- OVER:
  - game_over = 1.
  - add_valid and hit are ignored.
  - Scores are frozen.
- start in any state, priority over all else:
  - Scores cleared; lives = START_LIVES; counter cleared.
  - State to PLAY; any in-flight add is discarded.
- An add in flight completes through ADD0..ADD2 even if lives reaches 0; OVER is entered from the next PLAY cycle.

## Timing
- Reset values: score0/1/2 = 0, lives = START_LIVES, invuln = 0, game_over = 0, add_ready = 1, state PLAY, vsync_d = 0, counter = 0.
- Add handshake at edge N:
  - score0 updated at edge N+1.
  - If carry: score1 at N+2; if further carry: score2 at N+3.
  - add_ready high again the cycle after the last ADD state.
- Throughput: one add per 2, 3 or 4 cycles.
- Hit: lives and invuln update at the edge sampling hit, i.e. 1-cycle latency.
- Invuln duration: exactly INVULN_FRAMES vsync ticks after the hit edge.
- game_over rises 2 edges after lives reaches 0 when idle in PLAY:
  - Edge 1: the hit edge that sets lives = 0.
  - Edge 2: the PLAY → OVER edge.
- start takes effect at the next edge; all outputs show start values one cycle later.
- All outputs are registered; no combinational path from inputs to outputs, except add_ready, which is decoded from registered state only.

## Configuration
- SCORE_EXTRA_LIFE_EN:
  - Defined: each ADD2 hundreds-carry event (every 100 points, including the 999→000 wrap) grants +1 life, saturating at MAX_LIVES.
  - Undefined: ADD2 does not affect lives; lives only decrease or reload on start/reset.

## Test plan
- Reset → score 000, lives 3, add_ready 1, game_over 0, invuln 0; add_points=7 → score 007 at N+1; add 5 → score 012 at N+2, add_ready low exactly 2 cycles.
- Preload score 095, add 9 → score 104 at N+3, add_ready low 3 cycles; with SCORE_EXTRA_LIFE_EN lives 3→4, without it lives stays 3. Add 15 → treated as 9.
- Score 995, add 9 → score 004 (wrap); with the macro, lives +1, saturating at 9 if already 9.
- INVULN_FRAMES=2, hit → lives 2, invuln 1; second hit before 2 vsync ticks → ignored; after 2 ticks invuln 0, hit → lives 1.
- Three accepted hits → lives 0, game_over 1 two edges after the last hit, add_ready 0; further add_valid/hit ignored; start pulse → score 000, lives 3, game_over 0.
- Hit and ADD2 extra life in the same cycle, lives 3 → lives stays 3. Reset asserted mid-ADD1 → all reset values immediately, asynchronously.

Source files
------------

// File: rtl/game_stats_ctrl.sv
// game_stats_ctrl: score / lives keeper for the scoreboard renderer.
// Point-add requests arrive on a valid/ready handshake and are folded into a
// 3-digit BCD score one digit per cycle (ADD0..ADD2). Hits cost a life and open
// a vsync-counted invulnerability window. Lives at zero park the FSM in OVER
// until a start pulse.
// Optional feature macro: SCORE_EXTRA_LIFE_EN -- every hundreds carry (including
// the 999 -> 000 wrap) grants one extra life, saturating at MAX_LIVES.
module game_stats_ctrl #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned MAX_LIVES     = 9,
  parameter int unsigned INVULN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       add_valid,
  input  logic [3:0] add_points,
  output logic       add_ready,
  input  logic       hit,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] lives,
  output logic       invuln,
  output logic       game_over
);

  typedef enum logic [2:0] {PLAY, ADD0, ADD1, ADD2, OVER} state_e;

  localparam logic [3:0] START_L = 4'(START_LIVES);
  localparam logic [3:0] MAX_L   = 4'(MAX_LIVES);
  localparam logic [7:0] INV_L   = 8'(INVULN_FRAMES);

  state_e     state_q, state_d;
  logic [3:0] score0_q, score0_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [3:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] pts_q, pts_d;
  logic       vsync_d_q, vsync_d_d;

  logic       tick;
  logic       inc;
  logic       dec;
  logic [4:0] add_sum;
  logic [4:0] lives_sum;

  // Next-state: add sequencing, hit/extra-life accounting, invuln countdown, start override.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    score0_d  = score0_q;
    score1_d  = score1_q;
    score2_d  = score2_q;
    cnt_d     = cnt_q;
    pts_d     = pts_q;
    vsync_d_d = vsync;
    inc       = 1'b0;
    dec       = 1'b0;
    add_sum   = {1'b0, score0_q} + {1'b0, pts_q};
    tick      = vsync & ~vsync_d_q;

    if (tick && cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;

    case (state_q)
      PLAY: begin
        if (add_valid) begin
          pts_d   = (add_points > 4'd9) ? 4'd9 : add_points;
          state_d = ADD0;
        end else if (lives_q == 4'd0) begin
          state_d = OVER;
        end
      end
      ADD0: begin
        if (add_sum >= 5'd10) begin
          score0_d = 4'(add_sum - 5'd10);
          state_d  = ADD1;
        end else begin
          score0_d = add_sum[3:0];
          state_d  = PLAY;
        end
      end
      ADD1: begin
        if (score1_q == 4'd9) begin
          score1_d = 4'd0;
          state_d  = ADD2;
        end else begin
          score1_d = score1_q + 4'd1;
          state_d  = PLAY;
        end
      end
      ADD2: begin
        score2_d = (score2_q == 4'd9) ? 4'd0 : score2_q + 4'd1;
`ifdef SCORE_EXTRA_LIFE_EN
        inc      = 1'b1;
`else
        inc      = 1'b0;
`endif
        state_d  = PLAY;
      end
      OVER:    state_d = OVER;
      default: state_d = PLAY;
    endcase

    // A hit only lands outside OVER, with the window closed and a life left.
    if (state_q != OVER && hit && cnt_q == 8'd0 && lives_q != 4'd0) begin
      dec   = 1'b1;
      cnt_d = INV_L;
    end

    // dec implies lives_q > 0, so only the upper bound needs saturation.
    lives_sum = {1'b0, lives_q} + {4'd0, inc} - {4'd0, dec};
    lives_d   = (lives_sum > {1'b0, MAX_L}) ? MAX_L : lives_sum[3:0];

    if (start) begin
      state_d  = PLAY;
      score0_d = 4'd0;
      score1_d = 4'd0;
      score2_d = 4'd0;
      lives_d  = START_L;
      cnt_d    = 8'd0;
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PLAY;
      score0_q  <= 4'd0;
      score1_q  <= 4'd0;
      score2_q  <= 4'd0;
      lives_q   <= START_L;
      cnt_q     <= 8'd0;
      pts_q     <= 4'd0;
      vsync_d_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      state_q   <= state_d;
      score0_q  <= score0_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      pts_q     <= pts_d;
      vsync_d_q <= vsync_d_d;
    end
  end

  assign score0    = score0_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign lives     = lives_q;
  assign invuln    = (cnt_q != 8'd0);
  assign game_over = (state_q == OVER);
  assign add_ready = (state_q == PLAY);

endmodule

// File: tb/tb_game_stats_ctrl.sv
// Self-checking bench for game_stats_ctrl. The reference model keeps the score
// as a plain integer 0..999 and derives carries, busy cycles and extra lives
// from decimal arithmetic.
module tb_game_stats_ctrl;

  localparam int START_L = 3;
  localparam int MAX_L   = 9;
  localparam int INV_F   = 2;
`ifdef SCORE_EXTRA_LIFE_EN
  localparam int EXTRA_EN = 1;
`else
  localparam int EXTRA_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, vsync, start, add_valid, hit;
  logic [3:0] add_points;
  logic       add_ready, invuln, game_over;
  logic [3:0] score0, score1, score2, lives;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int m_score, m_lives, m_cnt;

  game_stats_ctrl #(
    .START_LIVES  (START_L),
    .MAX_LIVES    (MAX_L),
    .INVULN_FRAMES(INV_F)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .start     (start),
    .add_valid (add_valid),
    .add_points(add_points),
    .add_ready (add_ready),
    .hit       (hit),
    .score0    (score0),
    .score1    (score1),
    .score2    (score2),
    .lives     (lives),
    .invuln    (invuln),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_score(input string tag);
    check(tag, {20'd0, score2, score1, score0}, {20'd0, to_bcd(m_score)});
  endtask

  task automatic model_restart();
    m_score = 0;
    m_lives = START_L;
    m_cnt   = 0;
  endtask

  task automatic check_start_vals(input string tag);
    check_score({tag, "_score"});
    check({tag, "_lives"}, {28'd0, lives}, START_L);
    check({tag, "_ready"}, {31'd0, add_ready}, 1);
    check({tag, "_over"}, {31'd0, game_over}, 0);
    check({tag, "_invuln"}, {31'd0, invuln}, 0);
  endtask

  // One add transaction; optionally pulses hit while the FSM is in its third busy cycle.
  task automatic do_add(input int p, input bit hit_in_add2);
    int pts, old, low, low_exp, hund, tens, d;
    check("add_ready_idle", {31'd0, add_ready}, 1);
    pts     = (p > 9) ? 9 : p;
    old     = m_score;
    tens    = ((old % 10) + pts >= 10) ? 1 : 0;
    hund    = ((old % 100) + pts >= 100) ? 1 : 0;
    low_exp = 1 + tens + hund;
    add_valid  = 1'b1;
    add_points = 4'(p);
    @(negedge clk);
    add_valid  = 1'b0;
    add_points = 4'd0;
    low = 0;
    while (add_ready !== 1'b1 && low < 8) begin
      low++;
      if (hit_in_add2 && low == 3) hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
    end
    d = (hit_in_add2 && hund == 1 && m_cnt == 0 && m_lives > 0) ? 1 : 0;
    if (d == 1) m_cnt = INV_F;
    m_score = (old + pts) % 1000;
    m_lives = m_lives + hund * EXTRA_EN - d;
    if (m_lives > MAX_L) m_lives = MAX_L;
    check("add_busy_cycles", low, low_exp);
    check_score("add_score");
    check("add_lives", {28'd0, lives}, m_lives);
  endtask

  task automatic preload(input int target);
    int guard = 0;
    while (m_score < target && guard < 200) begin
      do_add((target - m_score > 9) ? 9 : target - m_score, 1'b0);
      guard++;
    end
    check_score("preload_score");
  endtask

  task automatic do_hit();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    if (m_cnt == 0 && m_lives > 0) begin
      m_lives--;
      m_cnt = INV_F;
    end
    check("hit_lives", {28'd0, lives}, m_lives);
    check("hit_invuln", {31'd0, invuln}, (m_cnt != 0) ? 1 : 0);
  endtask

  task automatic frame_tick();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    if (m_cnt > 0) m_cnt--;
    check("tick_invuln", {31'd0, invuln}, (m_cnt != 0) ? 1 : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_restart();
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; start = 1'b0;
    add_valid = 1'b0; add_points = 4'd0; hit = 1'b0;
    model_restart();
    repeat (2) @(negedge clk);
    check_start_vals("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_start_vals("reset_released");

    // Basic adds: no carry, then tens carry.
    do_add(7, 1'b0);
    do_add(5, 1'b0);

    // Hundreds carry from 095, then an out-of-range value clamped to 9.
    preload(95);
    do_add(9, 1'b0);
    do_add(15, 1'b0);

    // Randomized adds with idle frame ticks mixed in.
    repeat (30) begin
      do_add(int'($urandom_range(0, 15)), 1'b0);
      if ($urandom_range(0, 3) == 0) frame_tick();
    end

    // 999 -> 000 wrap.
    preload(995);
    do_add(9, 1'b0);

    // Restart and exercise the invulnerability window down to game over.
    pulse_start();
    check_start_vals("start1");
    do_hit();
    do_hit();
    frame_tick();
    do_hit();
    frame_tick();
    do_hit();
    frame_tick();
    frame_tick();
    do_hit();
    check("over_edge1", {31'd0, game_over}, 0);
    @(negedge clk);
    check("over_edge2", {31'd0, game_over}, 1);
    check("over_ready", {31'd0, add_ready}, 0);

    // Requests are ignored while over.
    add_valid = 1'b1; add_points = 4'd9; hit = 1'b1;
    @(negedge clk);
    add_valid = 1'b0; add_points = 4'd0; hit = 1'b0;
    repeat (3) @(negedge clk);
    check_score("over_score_frozen");
    check("over_lives", {28'd0, lives}, 0);
    check("over_hold", {31'd0, game_over}, 1);

    pulse_start();
    check_start_vals("start2");

    // Hit lands in the same cycle as the hundreds carry.
    preload(95);
    do_add(9, 1'b1);
    check("hit_add2_invuln", {31'd0, invuln}, 1);
    frame_tick();
    frame_tick();

    // Asynchronous reset in the middle of a carry sequence.
    check_score("pre_reset_score");
    add_valid = 1'b1; add_points = 4'd9;
    @(negedge clk);
    add_valid = 1'b0; add_points = 4'd0;
    @(negedge clk);
    check("mid_add_busy", {31'd0, add_ready}, 0);
    #2 reset = 1'b1;
    #1 model_restart();
    check_start_vals("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_add(7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
